// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg: shared types and default constants for the key debouncer.
//   db_state_e          per-channel FSM state (IDLE / COUNT)
//   DEBOUNCE_CYCLES_DEF default hold time in clk cycles (20 ms at 50 MHz)
//   KEY_IDLE_LVL        released level of an active-low key
package key_debounce_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } db_state_e;

  localparam int   DEBOUNCE_CYCLES_DEF = 1000000;
  localparam logic KEY_IDLE_LVL        = 1'b1;

endpackage

// File: rtl/key_debounce_if.sv
// key_debounce_if: key bundle between the board pins and the debounced levels.
//   key_in  raw active-low key pins (driven by master)
//   key_db  debounced level per channel (driven by slave)
//   busy    any channel currently timing a change (driven by slave)
//   key_chg one-cycle pulse when key_db changes (only with KEY_DEBOUNCE_CHG_EN)
interface key_debounce_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] key_in;
  logic [WIDTH-1:0] key_db;
  logic             busy;
`ifdef KEY_DEBOUNCE_CHG_EN
  logic [WIDTH-1:0] key_chg;

  modport master (output key_in, input key_db, input busy, input key_chg);
  modport slave  (input key_in, output key_db, output busy, output key_chg);
`else
  modport master (output key_in, input key_db, input busy);
  modport slave  (input key_in, output key_db, output busy);
`endif
endinterface

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one debounce channel.
//   Two-flop synchroniser, then an IDLE/COUNT FSM that lets the output follow
//   the synchronised input only after it has differed from the output for
//   DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   i_key       raw asynchronous key pin
//   o_key_db    debounced level
//   o_key_chg   one-cycle pulse with each o_key_db change (KEY_DEBOUNCE_CHG_EN)
//   o_busy      registered: channel is in COUNT
// Optional feature macro: KEY_DEBOUNCE_CHG_EN
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter logic RST_VAL         = KEY_IDLE_LVL
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key,
  output logic o_key_db,
`ifdef KEY_DEBOUNCE_CHG_EN
  output logic o_key_chg,
`endif
  output logic o_busy
);

  localparam int               CNT_W    = ($clog2(DEBOUNCE_CYCLES) > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam bit               SINGLE   = (DEBOUNCE_CYCLES == 1);

  logic             r_sync_p0;
  logic             r_sync_p1;
  db_state_e        r_state;
  db_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_key_db;
  logic             w_key_db_nxt;
  logic             r_busy;

  // Stage p0/p1: metastability synchroniser, no logic between the flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_p0 <= RST_VAL;
      r_sync_p1 <= RST_VAL;
    end else begin
      r_sync_p0 <= i_key;
      r_sync_p1 <= r_sync_p0;
    end
  end

  // Stage p2: FSM state, hold counter and debounced output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_key_db <= RST_VAL;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_key_db <= w_key_db_nxt;
      r_busy   <= (w_state_nxt == COUNT);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_key_db_nxt = r_key_db;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (r_sync_p1 != r_key_db) begin
          // A one-cycle hold time means the first differing sample is enough.
          if (SINGLE) begin
            w_key_db_nxt = r_sync_p1;
          end else begin
            w_state_nxt = COUNT;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
      end
      COUNT: begin
        if (r_sync_p1 == r_key_db) begin
          // Bounced back before the hold time elapsed: discard the count.
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_key_db_nxt = r_sync_p1;
          w_state_nxt  = IDLE;
          w_cnt_nxt    = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

`ifdef KEY_DEBOUNCE_CHG_EN
  logic r_key_chg;

  // Pulse lands on the same edge that updates r_key_db.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_chg <= 1'b0;
    end else begin
      r_key_chg <= (w_key_db_nxt != r_key_db);
    end
  end

  assign o_key_chg = r_key_chg;
`endif

  assign o_key_db = r_key_db;
  assign o_busy   = r_busy;

endmodule

// File: rtl/key_debounce.sv
// key_debounce: WIDTH independent debounce channels for active-low board keys.
//   Feeds clean levels to the downstream one-shot edge-to-pulse stage.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (release synchronised outside)
//   bus         key_debounce_if.slave: key_in in; key_db, busy (and key_chg) out
// Optional feature macro: KEY_DEBOUNCE_CHG_EN adds bus.key_chg change pulses.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int   WIDTH           = 4,
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter logic RST_VAL         = KEY_IDLE_LVL
) (
  input  logic           clk,
  input  logic           rst_n,
  key_debounce_if.slave  bus
);

  logic [WIDTH-1:0] w_key_db;
  logic [WIDTH-1:0] w_busy;
`ifdef KEY_DEBOUNCE_CHG_EN
  logic [WIDTH-1:0] w_key_chg;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RST_VAL         (RST_VAL)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_key     (bus.key_in[i]),
      .o_key_db  (w_key_db[i]),
`ifdef KEY_DEBOUNCE_CHG_EN
      .o_key_chg (w_key_chg[i]),
`endif
      .o_busy    (w_busy[i])
    );
  end

  // Each busy bit is already a flop output, so the OR adds no extra latency.
  assign bus.key_db  = w_key_db;
  assign bus.busy    = |w_busy;
`ifdef KEY_DEBOUNCE_CHG_EN
  assign bus.key_chg = w_key_chg;
`endif

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Multi-channel debouncer for the raw active-low push-buttons (KEY pins) on the board.
- Each channel synchronises its asynchronous pin into `clk`, then filters out contact bounce.
- Outputs clean, stable levels that feed directly into the downstream `oneshot` edge-to-pulse stage (`key_db` → `oneshot.edge_sig`).
- Idle level is 1 (button released), so the downstream falling-edge detector fires once per real press.

Parameters:
- WIDTH, 4: number of independent key channels.
- DEBOUNCE_CYCLES, 1000000: consecutive `clk` cycles an input must hold its new value before the output follows (20 ms at 50 MHz). Legal range is 1 to 2^24-1.
- RST_VAL, 1'b1: reset/idle level of every synchroniser stage and every output bit.

Ports:
- clk, input, 1: single system clock; all logic is on its rising edge.
- rst_n, input, 1: asynchronous active-low reset; release is synchronous to `clk` (handled outside this block).
- key_in, input, WIDTH: raw button pins, asynchronous to `clk`, active-low.
- key_db, output, WIDTH: debounced, registered level per channel.
- busy, output, 1: OR over all channels of (state == COUNT), registered.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - sync_q1, sync_q2 and key_db go to {WIDTH{RST_VAL}}.
  - All counters go to 0, all channel states to IDLE, busy to 0.
  - A reset asserted in the middle of a count discards that count; after release, the new value must be held for a full count again.
- Synchroniser:
  - Two flops per bit: sync_q1 <= key_in; sync_q2 <= sync_q1.
  - No logic between the two stages.
- Counter width: CNT_W = max(1, $clog2(DEBOUNCE_CYCLES)), a localparam. The counter never exceeds DEBOUNCE_CYCLES-1, so it never wraps.
- Per-channel FSM (channels fully independent):
  - IDLE:
    - cnt == 0.
    - If sync_q2 != key_db → go to COUNT. On this same edge cnt <= 1, unless DEBOUNCE_CYCLES == 1, in which case key_db <= sync_q2 immediately and the channel stays in IDLE.
  - COUNT:
    - If sync_q2 == key_db (bounce back) → go to IDLE, cnt <= 0, key_db unchanged.
    - Else if cnt == DEBOUNCE_CYCLES-1 → key_db <= sync_q2, cnt <= 0, go to IDLE.
    - Else cnt <= cnt + 1.
- Latency: if key_in changes before edge E0 and then stays stable, key_db updates on edge E(DEBOUNCE_CYCLES+1), i.e. DEBOUNCE_CYCLES+2 edges after the change.
- Glitch rejection: any glitch shorter than DEBOUNCE_CYCLES cycles, as seen at sync_q2, never reaches key_db.
- Simultaneous events: several channels may change on the same cycle; each counts on its own with no arbitration.
- A change that reverses while in COUNT resets that channel's count. A later reversal back restarts from 1.
- busy registers the OR of next-state == COUNT across all channels.

Optional Feature:
- Macro: KEY_DEBOUNCE_CHG_EN.
- When defined:
  - Adds output port key_chg[WIDTH-1:0].
  - Bit i pulses high for exactly one cycle, aligned with the cycle in which key_db[i] shows its new value.
  - key_chg resets to 0.
- When undefined: the port and its logic are absent; the rest of the behaviour is identical.

Decomposition:
- Package key_debounce_pkg holds:
  - state encoding typedef (IDLE = 1'b0, COUNT = 1'b1);
  - default constants DEBOUNCE_CYCLES_DEF = 1000000 and KEY_IDLE_LVL = 1'b1.
- Sub-module key_debounce_ch:
  - one channel: synchroniser, FSM, counter, key_db bit;
  - optional key_chg bit when the macro is defined;
  - exposes its own busy bit.
- key_debounce instantiates WIDTH copies in a generate loop and ORs the busy bits.

Test Plan (bench uses WIDTH=4, DEBOUNCE_CYCLES=8):
1. Hold rst_n=0 with key_in=4'h0 → key_db=4'hF and busy=0 throughout. Release → key_db becomes 4'h0 exactly 10 edges after release, and busy=1 from edge 3 through edge 9.
2. From idle 4'hF, set key_in[0]=0 before E0 and hold → key_db[0] falls on E9 (8+1) and no other bit moves. Release key_in[0] → key_db[0] rises 10 edges later.
3. Bounce on key_in[1]: pattern low 5 / high 2 / low 3 / high held → key_db[1] stays 1 and busy returns to 0 within 3 cycles of the last high.
4. key_in[2] and key_in[3] fall on the same cycle; key_in[3] rises again 4 cycles later → key_db[2] falls on E9, key_db[3] never changes.
5. key_in[0] low; assert rst_n=0 asynchronously at count 5 for 2 cycles, then release with key_in still low → key_db[0]=1 during reset, then falls exactly 10 edges after release.
6. With KEY_DEBOUNCE_CHG_EN defined, run scenario 2 → key_chg[0]=1 for exactly one cycle on the press and one cycle on the release, each coinciding with the key_db[0] transition; otherwise key_chg=4'h0.
